// File: rtl/exec_pkg.sv
// Shared constants for the execute/write-back stage: opcodes, FSM encoding and default widths.
package exec_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF = 3;
   localparam int unsigned MUL_CYCLES = DATA_W_DEF;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_WB   = 2'd2
   } state_t;

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, low W bits of a*b.
module iter_mul
   import exec_pkg::*;
#(
   parameter int unsigned W      = DATA_W_DEF,
   parameter int unsigned Cycles = MUL_CYCLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] product
);

   localparam int unsigned CntW = $clog2(Cycles);

   logic [W-1:0]    aQ, bQ, accQ, accD;
   logic [CntW-1:0] cntQ;
   logic            runQ;

   always_comb begin
      accD = accQ + (bQ[0] ? aQ : '0);
   end

   // product presents the post-step accumulator so the final step is visible alongside done
   assign done    = runQ && (cntQ == CntW'(Cycles - 1));
   assign product = accD;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aQ   <= '0;
         bQ   <= '0;
         accQ <= '0;
         cntQ <= '0;
         runQ <= 1'b0;
      end else if (start) begin
         aQ   <= a;
         bQ   <= b;
         accQ <= '0;
         cntQ <= '0;
         runQ <= 1'b1;
      end else if (runQ) begin
         accQ <= accD;
         aQ   <= aQ << 1;
         bQ   <= bQ >> 1;
         cntQ <= cntQ + 1'b1;
         if (done) runQ <= 1'b0;
      end
   end

endmodule

// File: rtl/exec_wb_unit.sv
// Execute/write-back stage closing the loop into the register-file write port.
// Optional flag outputs (flag_z/flag_n/flag_c) are built when EXEC_FLAGS_EN is defined.
module exec_wb_unit
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [2:0]        issue_op,
   input  logic [ADDR_W-1:0] issue_rs_even,
   input  logic [ADDR_W-1:0] issue_rs_odd,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic [ADDR_W-1:0] ReadRegEven,
   output logic [ADDR_W-1:0] ReadRegOdd,
   input  logic [DATA_W-1:0] ReadDataEven,
   input  logic [DATA_W-1:0] ReadDataOdd,
   output logic              WriteEn,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
`ifdef EXEC_FLAGS_EN
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_c,
`endif
   output logic              busy
);

   localparam int unsigned ShW = $clog2(DATA_W);

   state_t            stateQ, stateD;
   logic [ADDR_W-1:0] rdQ, rsEvenQ, rsOddQ, nextRd;
   logic [DATA_W-1:0] aluRes, nextRes, mulProduct;
   logic              accept, enterWb, mulStart, mulDone;

   assign issue_ready = rst && (stateQ == ST_IDLE);
   assign accept      = issue_valid && issue_ready;
   assign busy        = (stateQ != ST_IDLE);
   assign ReadRegEven = (stateQ == ST_IDLE) ? issue_rs_even : rsEvenQ;
   assign ReadRegOdd  = (stateQ == ST_IDLE) ? issue_rs_odd : rsOddQ;
   assign mulStart    = accept && (issue_op == OP_MUL);

   iter_mul #(
      .W      (DATA_W),
      .Cycles (DATA_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mulStart),
      .a       (ReadDataEven),
      .b       (ReadDataOdd),
      .done    (mulDone),
      .product (mulProduct)
   );

   // Single-cycle ops resolve straight from the accept-cycle operands
   always_comb begin
      aluRes = '0;
      unique case (issue_op)
         OP_ADD:  aluRes = ReadDataEven + ReadDataOdd;
         OP_SUB:  aluRes = ReadDataEven - ReadDataOdd;
         OP_AND:  aluRes = ReadDataEven & ReadDataOdd;
         OP_OR:   aluRes = ReadDataEven | ReadDataOdd;
         OP_XOR:  aluRes = ReadDataEven ^ ReadDataOdd;
         OP_SHL:  aluRes = ReadDataEven << ReadDataOdd[ShW-1:0];
         OP_SHR:  aluRes = ReadDataEven >> ReadDataOdd[ShW-1:0];
         default: aluRes = '0;
      endcase
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         ST_IDLE: if (accept) stateD = (issue_op == OP_MUL) ? ST_MUL : ST_WB;
         ST_MUL:  if (mulDone) stateD = ST_WB;
         ST_WB:   stateD = ST_IDLE;
         default: stateD = ST_IDLE;
      endcase
   end

   assign enterWb = (stateD == ST_WB);
   assign nextRes = (stateQ == ST_MUL) ? mulProduct : aluRes;
   assign nextRd  = (stateQ == ST_IDLE) ? issue_rd : rdQ;

`ifdef EXEC_FLAGS_EN
   logic aluCarry;

   // Unsigned overflow of ADD shows up as a wrapped sum below an operand
   always_comb begin
      aluCarry = 1'b0;
      if (stateQ == ST_IDLE) begin
         if (issue_op == OP_ADD) aluCarry = (aluRes < ReadDataEven);
         else if (issue_op == OP_SUB) aluCarry = (ReadDataEven < ReadDataOdd);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
      end else if (enterWb) begin
         flag_z <= (nextRes == '0);
         flag_n <= nextRes[DATA_W-1];
         flag_c <= aluCarry;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= ST_IDLE;
         rdQ       <= '0;
         rsEvenQ   <= '0;
         rsOddQ    <= '0;
         WriteEn   <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
      end else begin
         stateQ  <= stateD;
         WriteEn <= enterWb;
         if (accept) begin
            rdQ     <= issue_rd;
            rsEvenQ <= issue_rs_even;
            rsOddQ  <= issue_rs_odd;
         end
         if (enterWb) begin
            WriteReg  <= nextRd;
            WriteData <= nextRes;
         end
      end
   end

endmodule

// File: tb/tb_exec_wb_unit.sv
// Randomized bench for exec_wb_unit with a behavioural register-file and arithmetic model.
module tb_exec_wb_unit;

   logic        clk, rst;
   logic        issue_valid, issue_ready;
   logic [2:0]  issue_op;
   logic [2:0]  issue_rs_even, issue_rs_odd, issue_rd;
   logic [2:0]  ReadRegEven, ReadRegOdd;
   logic [15:0] ReadDataEven, ReadDataOdd;
   logic        WriteEn;
   logic [2:0]  WriteReg;
   logic [15:0] WriteData;
   logic        busy;
`ifdef EXEC_FLAGS_EN
   logic        flag_z, flag_n, flag_c;
`endif

   logic [15:0] rf  [8];
   logic [15:0] mrf [8];
   logic        preEn;
   logic [2:0]  preIdx;
   logic [15:0] preVal;

   int nTotal = 0;
   int nBad   = 0;

   exec_wb_unit dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_op      (issue_op),
      .issue_rs_even (issue_rs_even),
      .issue_rs_odd  (issue_rs_odd),
      .issue_rd      (issue_rd),
      .ReadRegEven   (ReadRegEven),
      .ReadRegOdd    (ReadRegOdd),
      .ReadDataEven  (ReadDataEven),
      .ReadDataOdd   (ReadDataOdd),
      .WriteEn       (WriteEn),
      .WriteReg      (WriteReg),
      .WriteData     (WriteData),
`ifdef EXEC_FLAGS_EN
      .flag_z        (flag_z),
      .flag_n        (flag_n),
      .flag_c        (flag_c),
`endif
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ReadDataEven = rf[ReadRegEven];
   assign ReadDataOdd  = rf[ReadRegOdd];

   always @(posedge clk) begin
      if (WriteEn) rf[WriteReg] <= WriteData;
      else if (preEn) rf[preIdx] <= preVal;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTotal++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // {carry/borrow, result} from plain integer arithmetic
   function automatic logic [16:0] refModel(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
      int unsigned ua, ub, r;
      logic        c;
      ua = a;
      ub = b;
      c  = 1'b0;
      case (op)
         3'd0: begin r = ua + ub; c = (r > 32'd65535); end
         3'd1: begin r = ua - ub; c = (ua < ub); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: r = ua << (ub % 16);
         3'd6: r = ua >> (ub % 16);
         default: r = ua * ub;
      endcase
      return {c, r[15:0]};
   endfunction

   task automatic preload(input logic [2:0] idx, input logic [15:0] val);
      @(negedge clk);
      preEn  = 1'b1;
      preIdx = idx;
      preVal = val;
      @(negedge clk);
      preEn    = 1'b0;
      mrf[idx] = val;
   endtask

   task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rse,
                      input logic [2:0] rso);
      logic [16:0] exp;
      int          cyc, rdyHigh, rsBad, busyLow;
      @(negedge clk);
      check("we_idle", WriteEn, 1'b0);
      issue_valid   = 1'b1;
      issue_op      = op;
      issue_rd      = rd;
      issue_rs_even = rse;
      issue_rs_odd  = rso;
      #1;
      check("ready_idle", issue_ready, 1'b1);
      check("rr_even", ReadRegEven, rse);
      check("rr_odd", ReadRegOdd, rso);
      exp     = refModel(op, mrf[rse], mrf[rso]);
      mrf[rd] = exp[15:0];
      @(posedge clk);
      cyc = 0; rdyHigh = 0; rsBad = 0; busyLow = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (issue_ready) rdyHigh++;
         if (!busy) busyLow++;
         if (ReadRegEven !== rse || ReadRegOdd !== rso) rsBad++;
         if (WriteEn === 1'b1 || cyc >= 40) break;
         // valid stays high with junk fields; the unit must ignore it
         issue_op      = 3'($urandom_range(0, 7));
         issue_rs_even = 3'($urandom_range(0, 7));
         issue_rs_odd  = 3'($urandom_range(0, 7));
         issue_rd      = 3'($urandom_range(0, 7));
      end
      issue_valid = 1'b0;
      check("wb_seen", WriteEn, 1'b1);
      check("latency", cyc, (op == 3'd7) ? 17 : 1);
      check("wreg", WriteReg, rd);
      check("wdata", WriteData, exp[15:0]);
      check("ready_low_busy", rdyHigh, 0);
      check("busy_high", busyLow, 0);
      check("rr_hold", rsBad, 0);
`ifdef EXEC_FLAGS_EN
      check("flag_z", flag_z, exp[15:0] == 16'h0);
      check("flag_n", flag_n, exp[15]);
      check("flag_c", flag_c, exp[16]);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int weSeen;
      rst = 1'b0; issue_valid = 1'b0; issue_op = '0;
      issue_rs_even = '0; issue_rs_odd = '0; issue_rd = '0;
      preEn = 1'b0; preIdx = '0; preVal = '0;
      #2;
      check("rst_we", WriteEn, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", issue_ready, 1'b0);
      check("rst_wdata", WriteData, 16'h0);
      check("rst_wreg", WriteReg, 3'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
      preload(3'd0, 16'h0000);
      preload(3'd2, 16'h0005);
      preload(3'd3, 16'h0007);
      preload(3'd4, 16'h0003);
      run(3'd0, 3'd1, 3'd2, 3'd3);

      preload(3'd6, 16'h0000);
      preload(3'd7, 16'h0001);
      run(3'd1, 3'd5, 3'd6, 3'd7);

      preload(3'd2, 16'h8001);
      preload(3'd3, 16'h0011);
      run(3'd5, 3'd1, 3'd2, 3'd3);
      preload(3'd2, 16'h8000);
      preload(3'd3, 16'h000F);
      run(3'd6, 3'd1, 3'd2, 3'd3);

      preload(3'd2, 16'h0102);
      preload(3'd3, 16'h0103);
      run(3'd7, 3'd1, 3'd2, 3'd3);

      // dependent pair issued back to back
      run(3'd0, 3'd4, 3'd4, 3'd4);
      run(3'd0, 3'd5, 3'd4, 3'd0);

      // reset during MUL cycle 8 aborts without a write
      preload(3'd6, 16'h1234);
      @(negedge clk);
      issue_valid = 1'b1; issue_op = 3'd7; issue_rd = 3'd6;
      issue_rs_even = 3'd2; issue_rs_odd = 3'd3;
      @(posedge clk);
      repeat (8) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_we", WriteEn, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_ready", issue_ready, 1'b0);
      check("abort_wdata", WriteData, 16'h0);
      issue_valid = 1'b0;
      weSeen = 0;
      repeat (3) begin
         @(negedge clk);
         if (WriteEn) weSeen++;
      end
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (WriteEn) weSeen++;
      end
      check("abort_no_write", weSeen, 0);
      check("abort_rd_kept", rf[6], mrf[6]);
      run(3'd0, 3'd3, 3'd2, 3'd3);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 2) == 0) preload(3'($urandom_range(0, 7)), 16'($urandom));
         run(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)));
      end

      @(negedge clk);
      for (int i = 0; i < 8; i++) check("final_rf", rf[i], mrf[i]);

      $display("test done: total=%0d bad=%0d", nTotal, nBad);
      $finish;
   end

endmodule
